// File: rtl/prime_bracket_pkg.sv
// Shared types and constants for the prime_bracket block.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : bracket-search FSM states
//   pt_state_t    : primality-tester FSM states
package prime_bracket_pkg;

    localparam int unsigned DEFAULT_WIDTH = 14;

    typedef enum logic [2:0] {
        IDLE,
        UP_INIT,
        UP_TEST,
        LOW_INIT,
        LOW_TEST,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PT_IDLE,
        PT_CHECK,
        PT_DIV,
        PT_EVAL
    } pt_state_t;

endpackage

// File: rtl/prime_test.sv
// Trial-division primality tester with a sequential restoring divider.
//   clk, reset : clock, async active-high reset
//   start      : pulse to begin testing `candidate`
//   candidate  : unsigned value to test (captured on start)
//   done       : one-cycle pulse when the verdict is ready
//   is_prime   : verdict, valid while done is high
module prime_test
    import prime_bracket_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] candidate,
    output logic             done,
    output logic             is_prime
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = 2 * WIDTH;

    pt_state_t        st_q, st_nxt;
    logic [WIDTH-1:0] cand_q, cand_nxt;
    logic [WIDTH-1:0] div_q, div_nxt;
    logic [WIDTH-1:0] dvd_q, dvd_nxt;
    logic [WIDTH:0]   rem_q, rem_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic             done_nxt, prime_nxt;

    logic [SW-1:0]    div_sq;
    logic [WIDTH:0]   rem_sh;

    // Divisor square at double width so it never wraps.
    assign div_sq = SW'(div_q) * SW'(div_q);
    // Restoring step: shift next dividend bit into the partial remainder.
    assign rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= PT_IDLE;
            cand_q   <= '0;
            div_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            is_prime <= 1'b0;
        end else begin
            st_q     <= st_nxt;
            cand_q   <= cand_nxt;
            div_q    <= div_nxt;
            dvd_q    <= dvd_nxt;
            rem_q    <= rem_nxt;
            cnt_q    <= cnt_nxt;
            done     <= done_nxt;
            is_prime <= prime_nxt;
        end
    end

    // Divisor sequencing 2,3,5,7,... and one remainder bit per cycle.
    always_comb begin
        st_nxt    = st_q;
        cand_nxt  = cand_q;
        div_nxt   = div_q;
        dvd_nxt   = dvd_q;
        rem_nxt   = rem_q;
        cnt_nxt   = cnt_q;
        done_nxt  = 1'b0;
        prime_nxt = is_prime;

        case (st_q)
            PT_IDLE: begin
                if (start) begin
                    cand_nxt = candidate;
                    div_nxt  = WIDTH'(2);
                    st_nxt   = PT_CHECK;
                end
            end
            PT_CHECK: begin
                if (cand_q < WIDTH'(2)) begin
                    done_nxt  = 1'b1;
                    prime_nxt = 1'b0;
                    st_nxt    = PT_IDLE;
                end else if (div_sq > SW'(cand_q)) begin
                    // Divisor list exhausted (also covers 2 and 3).
                    done_nxt  = 1'b1;
                    prime_nxt = 1'b1;
                    st_nxt    = PT_IDLE;
                end else begin
                    rem_nxt = '0;
                    dvd_nxt = cand_q;
                    cnt_nxt = CW'(WIDTH);
                    st_nxt  = PT_DIV;
                end
            end
            PT_DIV: begin
                if (rem_sh >= {1'b0, div_q}) begin
                    rem_nxt = rem_sh - {1'b0, div_q};
                end else begin
                    rem_nxt = rem_sh;
                end
                dvd_nxt = dvd_q << 1;
                cnt_nxt = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    st_nxt = PT_EVAL;
                end
            end
            PT_EVAL: begin
                if (rem_q == '0) begin
                    done_nxt  = 1'b1;
                    prime_nxt = 1'b0;
                    st_nxt    = PT_IDLE;
                end else begin
                    div_nxt = (div_q == WIDTH'(2)) ? WIDTH'(3) : div_q + WIDTH'(2);
                    st_nxt  = PT_CHECK;
                end
            end
            default: st_nxt = PT_IDLE;
        endcase
    end

endmodule

// File: rtl/prime_bracket.sv
// Finds the nearest primes above and below an input value.
//   clk, reset            : clock, async active-high reset
//   in_valid/in_ready     : request handshake, in_value = N
//   out_valid/out_ready   : result handshake
//   up_prime/up_found     : smallest prime above N (>= N if INCLUSIVE)
//   low_prime/low_found   : largest prime below N (<= N if INCLUSIVE)
module prime_bracket
    import prime_bracket_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned INCLUSIVE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] up_prime,
    output logic [WIDTH-1:0] low_prime,
    output logic             up_found,
    output logic             low_found
);

    localparam bit               INCL    = (INCLUSIVE != 0);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q, n_nxt;
    logic [WIDTH-1:0] cand_q, cand_nxt;
    logic             start_q, start_nxt;
    logic [WIDTH-1:0] up_prime_nxt, low_prime_nxt;
    logic             up_found_nxt, low_found_nxt;
    logic             pt_done, pt_prime;

    // Single tester shared by the upward and downward searches.
    prime_test #(.WIDTH(WIDTH)) u_prime_test (
        .clk       (clk),
        .reset     (reset),
        .start     (start_q),
        .candidate (cand_q),
        .done      (pt_done),
        .is_prime  (pt_prime)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            n_q       <= '0;
            cand_q    <= '0;
            start_q   <= 1'b0;
            up_prime  <= '0;
            low_prime <= '0;
            up_found  <= 1'b0;
            low_found <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            n_q       <= n_nxt;
            cand_q    <= cand_nxt;
            start_q   <= start_nxt;
            up_prime  <= up_prime_nxt;
            low_prime <= low_prime_nxt;
            up_found  <= up_found_nxt;
            low_found <= low_found_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Bracket search sequencing.
    always_comb begin
        state_nxt     = state;
        n_nxt         = n_q;
        cand_nxt      = cand_q;
        start_nxt     = 1'b0;
        up_prime_nxt  = up_prime;
        low_prime_nxt = low_prime;
        up_found_nxt  = up_found;
        low_found_nxt = low_found;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    n_nxt     = in_value;
                    state_nxt = UP_INIT;
                end
            end
            UP_INIT: begin
                if (!INCL && n_q == MAX_VAL) begin
                    up_found_nxt = 1'b0;
                    up_prime_nxt = '0;
                    state_nxt    = LOW_INIT;
                end else begin
                    cand_nxt  = INCL ? n_q : n_q + WIDTH'(1);
                    start_nxt = 1'b1;
                    state_nxt = UP_TEST;
                end
            end
            UP_TEST: begin
                if (pt_done) begin
                    if (pt_prime) begin
                        up_prime_nxt = cand_q;
                        up_found_nxt = 1'b1;
                        state_nxt    = LOW_INIT;
                    end else if (cand_q == MAX_VAL) begin
                        up_prime_nxt = '0;
                        up_found_nxt = 1'b0;
                        state_nxt    = LOW_INIT;
                    end else begin
                        cand_nxt  = cand_q + WIDTH'(1);
                        start_nxt = 1'b1;
                    end
                end
            end
            LOW_INIT: begin
                // Non-inclusive start is N-1, so N<3 leaves nothing >= 2.
                if (n_q < (INCL ? WIDTH'(2) : WIDTH'(3))) begin
                    low_found_nxt = 1'b0;
                    low_prime_nxt = '0;
                    state_nxt     = DONE;
                end else begin
                    cand_nxt  = INCL ? n_q : n_q - WIDTH'(1);
                    start_nxt = 1'b1;
                    state_nxt = LOW_TEST;
                end
            end
            LOW_TEST: begin
                if (pt_done) begin
                    if (pt_prime) begin
                        low_prime_nxt = cand_q;
                        low_found_nxt = 1'b1;
                        state_nxt     = DONE;
                    end else if (cand_q == WIDTH'(2)) begin
                        low_prime_nxt = '0;
                        low_found_nxt = 1'b0;
                        state_nxt     = DONE;
                    end else begin
                        cand_nxt  = cand_q - WIDTH'(1);
                        start_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prime_bracket.sv
// Scoreboard bench: one exclusive and one inclusive prime_bracket instance.
module tb_prime_bracket;

    localparam int unsigned W       = 14;
    localparam int          MAXV    = (1 << W) - 1;
    localparam int          TIMEOUT = 60000;

    typedef struct {
        int up;
        int lo;
        int uf;
        int lf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         iv0, ir0, ov0, or0, uf0, lf0;
    logic [W-1:0] ival0, up0, lo0;
    logic         iv1, ir1, ov1, or1, uf1, lf1;
    logic [W-1:0] ival1, up1, lo1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    prime_bracket #(.WIDTH(W), .INCLUSIVE(0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv0), .in_ready(ir0), .in_value(ival0),
        .out_valid(ov0), .out_ready(or0),
        .up_prime(up0), .low_prime(lo0), .up_found(uf0), .low_found(lf0)
    );

    prime_bracket #(.WIDTH(W), .INCLUSIVE(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv1), .in_ready(ir1), .in_value(ival1),
        .out_valid(ov1), .out_ready(or1),
        .up_prime(up1), .low_prime(lo1), .up_found(uf1), .low_found(lf1)
    );

    // Reference model: plain trial division and linear scans.
    function automatic bit ref_prime(input int c);
        if (c < 2) return 1'b0;
        for (int d = 2; d * d <= c; d++) begin
            if (c % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t model(input int n, input bit incl);
        exp_t r;
        r.up = 0; r.lo = 0; r.uf = 0; r.lf = 0;
        for (int c = (incl ? n : n + 1); c <= MAXV; c++) begin
            if (ref_prime(c)) begin
                r.up = c; r.uf = 1;
                break;
            end
        end
        for (int c = (incl ? n : n - 1); c >= 2; c--) begin
            if (ref_prime(c)) begin
                r.lo = c; r.lf = 1;
                break;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic cmp_result(input string tag, input exp_t e,
                              input int up, input int lo, input int uf, input int lf);
        check({tag, " up_prime"},  up, e.up);
        check({tag, " low_prime"}, lo, e.lo);
        check({tag, " up_found"},  uf, e.uf);
        check({tag, " low_found"}, lf, e.lf);
    endtask

    // Monitor: compare every accepted result against the scoreboard.
    always @(negedge clk) begin
        if (ov0 && or0) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut0 unexpected result: up=%0d low=%0d", up0, lo0);
            end else begin
                e0 = q0.pop_front();
                cmp_result("dut0", e0, int'(up0), int'(lo0), int'(uf0), int'(lf0));
            end
        end
        if (ov1 && or1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL dut1 unexpected result: up=%0d low=%0d", up1, lo1);
            end else begin
                e1 = q1.pop_front();
                cmp_result("dut1", e1, int'(up1), int'(lo1), int'(uf1), int'(lf1));
            end
        end
    end

    function automatic int pending(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit ready_of(input int idx);
        return (idx == 0) ? ir0 : ir1;
    endfunction

    // Issue one request at a negedge and wait for its result to be consumed.
    task automatic send(input int idx, input int n);
        int guard;
        guard = 0;
        while (!ready_of(idx) && guard < TIMEOUT) begin
            @(negedge clk); guard++;
        end
        if (guard >= TIMEOUT) check("in_ready timeout", 0, 1);
        if (idx == 0) begin
            q0.push_back(model(n, 1'b0));
            iv0 = 1'b1; ival0 = W'(n);
        end else begin
            q1.push_back(model(n, 1'b1));
            iv1 = 1'b1; ival1 = W'(n);
        end
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0;
        guard = 0;
        while (pending(idx) != 0 && guard < TIMEOUT) begin
            @(negedge clk); guard++;
        end
        if (guard >= TIMEOUT) begin
            $display("FAIL result timeout dut%0d N=%0d", idx, n);
            n_cmp++; n_fail++;
            if (idx == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    logic [W-1:0] h_up, h_lo;
    logic         h_uf, h_lf;

    initial begin
        int guard;
        reset = 1'b1;
        iv0 = 1'b0; ival0 = '0; or0 = 1'b1;
        iv1 = 1'b0; ival1 = '0; or1 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready",  int'(ir0), 1);
        check("reset out_valid", int'(ov0), 0);
        check("reset up_prime",  int'(up0), 0);
        check("reset low_prime", int'(lo0), 0);
        check("reset up_found",  int'(uf0), 0);
        check("reset low_found", int'(lf0), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed boundaries, exclusive instance.
        send(0, 100);
        send(0, 2);
        send(0, 0);
        send(0, 1);
        send(0, 3);
        send(0, 16383);
        send(0, 16382);
        // Directed boundaries, inclusive instance.
        send(1, 97);
        send(1, 96);
        send(1, 0);
        send(1, 1);
        send(1, 2);
        send(1, 16383);

        // Randomized requests.
        for (int i = 0; i < 10; i++) send(0, int'($urandom_range(0, 2000)));
        for (int i = 0; i < 6; i++)  send(1, int'($urandom_range(0, 2000)));

        // Back-pressure: hold out_ready low in DONE, pulse in_valid.
        @(posedge clk); #1 or0 = 1'b0;
        @(negedge clk);
        q0.push_back(model(100, 1'b0));
        iv0 = 1'b1; ival0 = W'(100);
        @(negedge clk);
        iv0 = 1'b0;
        guard = 0;
        while (!ov0 && guard < TIMEOUT) begin
            @(negedge clk); guard++;
        end
        check("hold reached DONE", int'(ov0), 1);
        h_up = up0; h_lo = lo0; h_uf = uf0; h_lf = lf0;
        check("hold up_prime 101", int'(h_up), 101);
        check("hold low_prime 97", int'(h_lo), 97);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin iv0 = 1'b1; ival0 = W'(50); end
            @(negedge clk);
            iv0 = 1'b0;
            check("hold out_valid", int'(ov0), 1);
            check("hold in_ready",  int'(ir0), 0);
            check("hold stable up",  int'(up0), int'(h_up));
            check("hold stable low", int'(lo0), int'(h_lo));
            check("hold stable flags", int'({uf0, lf0}), int'({h_uf, h_lf}));
        end
        @(posedge clk); #1 or0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("accept in_ready", int'(ir0), 1);
        check("accept out_valid", int'(ov0), 0);
        check("hold queue drained", q0.size(), 0);
        repeat (40) @(negedge clk);

        // Reset pulse in the middle of a search.
        iv0 = 1'b1; ival0 = W'(1000);
        @(negedge clk);
        iv0 = 1'b0;
        repeat (20) @(negedge clk);
        check("abort busy in_ready", int'(ir0), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort in_ready", int'(ir0), 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ov0) check("abort out_valid", int'(ov0), 0);
        end
        send(0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
